// File: rtl/reg_file_16b_rd_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_16b_rd_if
// Description : Bus bundle for reg_file_16b_rd. It carries the write port, two
//               read ports and the valid/ready dump stream. The master drives
//               requests. The slave (the register file) drives data back.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_16b_rd_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
);
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_a_addr;
    logic [WIDTH-1:0] rd_a_data;
    logic [AW-1:0]    rd_b_addr;
    logic [WIDTH-1:0] rd_b_data;
    logic             dump_start;
    logic             dump_ready;
    logic             dump_valid;
    logic [AW-1:0]    dump_idx;
    logic [WIDTH-1:0] dump_data;
    logic             dump_busy;
    logic             dump_done;

    modport master (
        output wr_en, wr_addr, wr_data, rd_a_addr, rd_b_addr,
               dump_start, dump_ready,
        input  rd_a_data, rd_b_data, dump_valid, dump_idx, dump_data,
               dump_busy, dump_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_a_addr, rd_b_addr,
               dump_start, dump_ready,
        output rd_a_data, rd_b_data, dump_valid, dump_idx, dump_data,
               dump_busy, dump_done
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_16b_rd.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_16b_rd
// Description : DEPTH x WIDTH register file with one write port, two
//               registered read ports and a sequential dump reader that
//               streams every register over valid/ready. Register 0 always
//               reads as zero.
//               Optional macro REGFILE_WRITE_BYPASS_EN: a read or dump
//               capture of the address being written returns the new data
//               (write-first). When the macro is undefined, it returns the
//               old data (read-first).
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_16b_rd #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    reg_file_16b_rd_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SHOW = 2'd2,
        S_DONE = 2'd3
    } state_t;

    logic [WIDTH-1:0] w_regs [DEPTH];

    // Entry 0 is a constant zero and has no storage.
    assign w_regs[0] = '0;

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_regs
            logic [WIDTH-1:0] r_word;

            // Enable-gated word: it holds its value unless it is addressed by a write.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_word <= '0;
                end else if (bus.wr_en && (bus.wr_addr == AW'(gi))) begin
                    r_word <= bus.wr_data;
                end
            end

            assign w_regs[gi] = r_word;
        end
    endgenerate

    // Read-side values, with optional same-cycle forwarding of the write data.
    logic [WIDTH-1:0] w_rd_a_word;
    logic [WIDTH-1:0] w_rd_b_word;
    logic [WIDTH-1:0] w_load_word;
    logic [AW-1:0]    r_idx;

`ifdef REGFILE_WRITE_BYPASS_EN
    logic w_wr_live;
    assign w_wr_live   = bus.wr_en && (bus.wr_addr != '0);
    assign w_rd_a_word = (w_wr_live && (bus.wr_addr == bus.rd_a_addr)) ? bus.wr_data
                                                                       : w_regs[bus.rd_a_addr];
    assign w_rd_b_word = (w_wr_live && (bus.wr_addr == bus.rd_b_addr)) ? bus.wr_data
                                                                       : w_regs[bus.rd_b_addr];
    assign w_load_word = (w_wr_live && (bus.wr_addr == r_idx))         ? bus.wr_data
                                                                       : w_regs[r_idx];
`else
    assign w_rd_a_word = w_regs[bus.rd_a_addr];
    assign w_rd_b_word = w_regs[bus.rd_b_addr];
    assign w_load_word = w_regs[r_idx];
`endif

    logic [WIDTH-1:0] r_rd_a_data;
    logic [WIDTH-1:0] r_rd_b_data;

    // Operand-fetch read ports: both ports have one cycle of latency and no enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_a_data <= '0;
            r_rd_b_data <= '0;
        end else begin
            r_rd_a_data <= w_rd_a_word;
            r_rd_b_data <= w_rd_b_word;
        end
    end

    assign bus.rd_a_data = r_rd_a_data;
    assign bus.rd_b_data = r_rd_b_data;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    w_idx_nxt;
    logic             w_load;
    logic             w_valid;
    logic             w_busy;
    logic             w_done;
    logic [AW-1:0]    r_dump_idx;
    logic [WIDTH-1:0] r_dump_data;

    // Dump FSM state and index register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Dump FSM next-state and outputs. A word leaves SHOW only when it is accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        w_valid     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.dump_start) begin
                    w_state_nxt = S_LOAD;
                    w_idx_nxt   = '0;
                end
            end
            S_LOAD: begin
                w_busy      = 1'b1;
                w_load      = 1'b1;
                w_state_nxt = S_SHOW;
            end
            S_SHOW: begin
                w_busy  = 1'b1;
                w_valid = 1'b1;
                if (bus.dump_ready) begin
                    if (r_idx == AW'(DEPTH - 1)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + AW'(1);
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Snapshot of the word being dumped, captured in LOAD and held through SHOW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dump_idx  <= '0;
            r_dump_data <= '0;
        end else if (w_load) begin
            r_dump_idx  <= r_idx;
            r_dump_data <= w_load_word;
        end
    end

    assign bus.dump_valid = w_valid;
    assign bus.dump_busy  = w_busy;
    assign bus.dump_done  = w_done;
    assign bus.dump_idx   = r_dump_idx;
    assign bus.dump_data  = r_dump_data;

endmodule
`default_nettype wire

// File: doc/reg_file_16b_rd.md
Name: reg_file_16b_rd

Overview:
- 8-entry x 16-bit register file for the RISC datapath: one write port, two registered read ports, and a sequential dump reader.
- Storage follows the enable-gated 16-bit register style already used in the datapath: a word holds its value unless written.
- Read ports feed operand fetch.
- The dump reader streams every register out over a valid/ready handshake for debug/LED/UART readback.

Parameters:
- WIDTH, 16, data width of each register.
- DEPTH, 8, number of registers; must be a power of two and at least 2.
- AW, 3, address width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write enable.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data.
- rd_a_addr  in  AW  read port A address.
- rd_a_data  out  WIDTH  read port A data, registered.
- rd_b_addr  in  AW  read port B address.
- rd_b_data  out  WIDTH  read port B data, registered.
- dump_start  in  1  request a full register dump.
- dump_ready  in  1  consumer accepts the current dump word.
- dump_valid  out  1  dump word present.
- dump_idx  out  AW  register index of the dump word.
- dump_data  out  WIDTH  dump word.
- dump_busy  out  1  dump in progress.
- dump_done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). While rst_n=0:
  - all registers = 0.
  - rd_a_data = rd_b_data = 0.
  - dump_valid = dump_busy = dump_done = 0; dump_idx = 0; dump_data = 0.
  - FSM = IDLE.
  - Reset mid-dump aborts the dump immediately; no done pulse.
- Register 0 is hardwired zero:
  - A write to address 0 is ignored.
  - Reads and dump of index 0 always return 0.
- Write: at a rising edge, if wr_en=1 and wr_addr!=0, then regs[wr_addr] <= wr_data. Otherwise every register holds.
- Read ports:
  - Latency 1: rd_x_data <= regs[rd_x_addr] at every rising edge; no enable.
  - Both ports are independent and may use the same address.
- Same-cycle read and write to the same non-zero address: see Optional Feature.
- Dump FSM states: IDLE, LOAD, SHOW, DONE.
  - IDLE: dump_busy=0. On dump_start=1 go to LOAD with idx=0.
  - LOAD: capture dump_data <= regs[idx], set dump_idx <= idx and dump_valid <= 1, go to SHOW. dump_busy=1.
  - SHOW: dump_valid=1; dump_data and dump_idx are held stable.
    - dump_ready=1 and idx=DEPTH-1: dump_valid <= 0, go to DONE.
    - dump_ready=1 otherwise: dump_valid <= 0, idx++, go to LOAD.
    - dump_ready=0: stay in SHOW.
  - DONE: dump_done=1 for exactly one cycle, dump_busy=0, go to IDLE.
- dump_start is ignored unless the FSM is in IDLE.
- Handshake:
  - A word transfers on a cycle where dump_valid=1 and dump_ready=1.
  - Maximum rate is one word per 2 cycles.
  - dump_ready may be held high continuously.
- Writes and reads continue normally during a dump. Each dump word is a snapshot taken in its LOAD cycle.
- idx does not wrap within a dump.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: if wr_en=1 and the address equals wr_addr (non-zero) in the same cycle, then rd_a_data, rd_b_data and LOAD capture return wr_data (write-first).
- Undefined: they return the pre-write register value (read-first). The written value is visible one cycle later.

Test Plan:
- Reset then idle: hold rst_n=0 for 35 ns, release, read addr 0..7 -> every rd_x_data = 0x0000; dump_valid/busy/done = 0.
- Write and read: write 0x000A to R3 and 0x0014 to R5, then rd_a_addr=3, rd_b_addr=5 -> next cycle rd_a_data=0x000A, rd_b_data=0x0014. Write 0x1234 to R0 -> R0 reads 0x0000.
- Hold: wr_en=0 while wr_data changes 30 -> 40 -> R3 still 0x000A. wr_en=1, wr_addr=3, wr_data=40 -> R3=0x0028.
- Read-during-write on R4 (old 0x0011, new 0x0022):
  - macro undefined -> rd_a_data=0x0011, then 0x0022.
  - REGFILE_WRITE_BYPASS_EN defined -> 0x0022 immediately.
- Dump with back-pressure: preload Rn=0x0100+n (n=1..7), pulse dump_start, hold dump_ready=0 for 3 cycles on index 2 -> words idx 0..7 = 0x0000, 0x0101 .. 0x0107 in order. dump_data stable while stalled. dump_done pulses once, after idx 7 is accepted. A second dump_start while busy is ignored.
- Reset mid-dump: assert rst_n=0 during the SHOW state of idx 4 -> dump_valid=0, busy=0, no done pulse, all registers = 0. A later dump returns all zeros.
